// File: rtl/fuzz_vec_driver_pkg.sv
// Shared types and defaults for the fuzz-harness vector driver.
// Optional feature macro: FUZZ_VEC_DRV_PARITY_EN (adds m_parity on the response stream).
package fuzz_vec_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    HOLD = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_WORD_W = 32;
  localparam int DEF_VEC_W  = 96;

  // Number of stream words that make up one vector.
  function automatic int calc_nw(input int vec_w, input int word_w);
    return vec_w / word_w;
  endfunction

endpackage

// File: rtl/fuzz_vec_driver_if.sv
// Stimulus and response stream bundle between the host link and the vector driver.
// Optional feature macro: FUZZ_VEC_DRV_PARITY_EN (adds m_parity).
interface fuzz_vec_driver_if #(
  parameter int WORD_W = 32
);

  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [WORD_W-1:0] m_data;
  logic              m_last;
`ifdef FUZZ_VEC_DRV_PARITY_EN
  logic              m_parity;
`endif

`ifdef FUZZ_VEC_DRV_PARITY_EN
  modport slave  (input  s_valid, s_data, m_ready,
                  output s_ready, m_valid, m_data, m_last, m_parity);
  modport master (output s_valid, s_data, m_ready,
                  input  s_ready, m_valid, m_data, m_last, m_parity);
`else
  modport slave  (input  s_valid, s_data, m_ready,
                  output s_ready, m_valid, m_data, m_last);
  modport master (output s_valid, s_data, m_ready,
                  input  s_ready, m_valid, m_data, m_last);
`endif

endinterface

// File: rtl/fuzz_vec_driver_resp_ser.sv
// Capture register plus serializer: latches the DUT result vector on cap_en_i and
// returns it LSB word first with registered valid/data/last (and parity when enabled).
// Optional feature macro: FUZZ_VEC_DRV_PARITY_EN.
module fuzz_vec_resp_ser
  import fuzz_vec_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int VEC_W  = DEF_VEC_W
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              cap_en_i,
  input  logic [VEC_W-1:0]  vec_i,
  input  logic              m_ready_i,
  output logic              m_valid_o,
  output logic [WORD_W-1:0] m_data_o,
  output logic              m_last_o,
`ifdef FUZZ_VEC_DRV_PARITY_EN
  output logic              m_parity_o,
`endif
  output logic              done_o
);

  localparam int NW = calc_nw(VEC_W, WORD_W);
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;

  logic [VEC_W-1:0]  cap_q,   cap_d;
  logic [IW-1:0]     idx_q,   idx_d;
  logic              valid_q, valid_d;
  logic [WORD_W-1:0] data_q,  data_d;
  logic              last_q,  last_d;
`ifdef FUZZ_VEC_DRV_PARITY_EN
  logic              par_q,   par_d;
`endif
  logic              hs;

  assign hs     = valid_q & m_ready_i;
  assign done_o = hs & last_q;

  // Next-state for capture, word index and the registered response word.
  always_comb begin
    cap_d   = cap_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (cap_en_i) begin
      cap_d   = vec_i;
      idx_d   = '0;
      valid_d = 1'b1;
      data_d  = vec_i[0 +: WORD_W];
      last_d  = (NW == 1);
    end else if (hs) begin
      if (last_q) begin
        idx_d   = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        idx_d  = idx_q + 1'b1;
        data_d = cap_q[int'(idx_d) * WORD_W +: WORD_W];
        last_d = (idx_d == IW'(NW - 1));
      end
    end
`ifdef FUZZ_VEC_DRV_PARITY_EN
    par_d = ~^data_d;
`endif
  end

  // Response state registers; everything clears asynchronously on reset.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      cap_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
`ifdef FUZZ_VEC_DRV_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      cap_q   <= cap_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
`ifdef FUZZ_VEC_DRV_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign m_valid_o  = valid_q;
  assign m_data_o   = data_q;
  assign m_last_o   = last_q;
`ifdef FUZZ_VEC_DRV_PARITY_EN
  assign m_parity_o = par_q;
`endif

endmodule

// File: rtl/fuzz_vec_driver.sv
// Fuzz-harness vector driver: assembles clock/data vectors from a word stream,
// applies both to the DUT on one edge, holds them HOLD_CYCLES edges, then
// captures and streams back the DUT result vector.
// Optional feature macro: FUZZ_VEC_DRV_PARITY_EN (m_parity on the response stream).
module fuzz_vec_driver
  import fuzz_vec_pkg::*;
#(
  parameter int WORD_W      = DEF_WORD_W,
  parameter int VEC_W       = DEF_VEC_W,
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clkin,
  input  logic              rst,
  fuzz_vec_driver_if.slave  bus,
  output logic [VEC_W-1:0]  dut_clkin_data,
  output logic [VEC_W-1:0]  dut_in_data,
  input  logic [VEC_W-1:0]  dut_out_data
);

  localparam int NW     = calc_nw(VEC_W, WORD_W);
  localparam int NWORDS = 2 * NW;
  localparam int CW     = $clog2(NWORDS);
  localparam int HW     = 8;

  state_t             state_q, state_d;
  logic [CW-1:0]      wcnt_q,  wcnt_d;
  logic [HW-1:0]      hold_q,  hold_d;
  logic [2*VEC_W-1:0] shadow_q, shadow_d;
  logic [VEC_W-1:0]   clkv_q,  clkv_d;
  logic [VEC_W-1:0]   datv_q,  datv_d;

  logic s_ready;
  logic accept;
  logic last_word;
  logic cap_en;
  logic resp_done;

  assign accept    = bus.s_valid & s_ready;
  assign last_word = (wcnt_q == CW'(NWORDS - 1));

  // FSM state register.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  // FSM next-state: apply on the final stimulus word, capture at end of hold,
  // return to loading after the last response handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (accept && last_word)              state_d = HOLD;
      HOLD:    if (hold_q == HW'(HOLD_CYCLES - 1))   state_d = RESP;
      RESP:    if (resp_done)                        state_d = LOAD;
      default:                                       state_d = LOAD;
    endcase
  end

  // FSM outputs: stimulus ready only while loading and out of reset; capture strobe.
  always_comb begin
    s_ready = 1'b0;
    cap_en  = 1'b0;
    unique case (state_q)
      LOAD:    s_ready = ~rst;
      HOLD:    cap_en  = (hold_q == HW'(HOLD_CYCLES - 1));
      default: ;
    endcase
  end

  // Datapath next-state: shadow fill, atomic vector apply, hold counting.
  always_comb begin
    shadow_d = shadow_q;
    wcnt_d   = wcnt_q;
    hold_d   = hold_q;
    clkv_d   = clkv_q;
    datv_d   = datv_q;
    if (accept) begin
      shadow_d[int'(wcnt_q) * WORD_W +: WORD_W] = bus.s_data;
      if (last_word) begin
        wcnt_d = '0;
        hold_d = '0;
        clkv_d = shadow_d[0 +: VEC_W];
        datv_d = shadow_d[VEC_W +: VEC_W];
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
    end
    if ((state_q == HOLD) && !cap_en) begin
      hold_d = hold_q + 1'b1;
    end
  end

  // Datapath registers; DUT vectors persist until the next apply.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      wcnt_q   <= '0;
      hold_q   <= '0;
      clkv_q   <= '0;
      datv_q   <= '0;
    end else begin
      shadow_q <= shadow_d;
      wcnt_q   <= wcnt_d;
      hold_q   <= hold_d;
      clkv_q   <= clkv_d;
      datv_q   <= datv_d;
    end
  end

  assign bus.s_ready    = s_ready;
  assign dut_clkin_data = clkv_q;
  assign dut_in_data    = datv_q;

  fuzz_vec_resp_ser #(
    .WORD_W (WORD_W),
    .VEC_W  (VEC_W)
  ) u_resp_ser (
    .clkin      (clkin),
    .rst        (rst),
    .cap_en_i   (cap_en),
    .vec_i      (dut_out_data),
    .m_ready_i  (bus.m_ready),
    .m_valid_o  (bus.m_valid),
    .m_data_o   (bus.m_data),
    .m_last_o   (bus.m_last),
`ifdef FUZZ_VEC_DRV_PARITY_EN
    .m_parity_o (bus.m_parity),
`endif
    .done_o     (resp_done)
  );

endmodule

// File: tb/tb_fuzz_vec_driver.sv
// Bench for fuzz_vec_driver: directed and randomized transactions against a
// word-level reference model of vector assembly, hold latency and response order.
module tb_fuzz_vec_driver;

  localparam int WORD_W = 32;
  localparam int VEC_W  = 96;
  localparam int NW     = VEC_W / WORD_W;
  localparam int HOLD   = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [VEC_W-1:0] dut_clkin_data;
  logic [VEC_W-1:0] dut_in_data;
  logic [VEC_W-1:0] dut_out_data;

  fuzz_vec_driver_if #(.WORD_W(WORD_W)) bus();

  fuzz_vec_driver #(
    .WORD_W      (WORD_W),
    .VEC_W       (VEC_W),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clkin          (clk),
    .rst            (rst),
    .bus            (bus),
    .dut_clkin_data (dut_clkin_data),
    .dut_in_data    (dut_in_data),
    .dut_out_data   (dut_out_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WORD_W-1:0] words [2*NW];
  logic [VEC_W-1:0]  exp_clk = '0;
  logic [VEC_W-1:0]  exp_dat = '0;

  task automatic check(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VEC_W-1:0] rand96();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic send_word(input logic [WORD_W-1:0] w);
    int n;
    n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = w;
    while (n <= 100) begin
      @(negedge clk);
      if (bus.s_ready) break;
      n++;
      @(posedge clk);
    end
    if (n > 100) check("s_ready_wait", VEC_W'(bus.s_ready), VEC_W'(1));
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  // One full transaction: load 2*NW words, hold, collect NW responses.
  task automatic run_txn(input bit vary, input int stall_first);
    logic [VEC_W-1:0]  capv;
    logic [WORD_W-1:0] exp_w;
    int idx, cyc, stall;
    for (int k = 0; k < 2*NW-1; k++) send_word(words[k]);
    check("no_partial_clk", dut_clkin_data, exp_clk);
    check("no_partial_dat", dut_in_data, exp_dat);
    send_word(words[2*NW-1]);
    exp_clk = '0;
    exp_dat = '0;
    for (int k = 0; k < NW; k++) begin
      exp_clk = exp_clk | (VEC_W'(words[k])      << (WORD_W*k));
      exp_dat = exp_dat | (VEC_W'(words[NW + k]) << (WORD_W*k));
    end
    check("apply_clk", dut_clkin_data, exp_clk);
    check("apply_dat", dut_in_data, exp_dat);
    check("s_ready_in_hold", VEC_W'(bus.s_ready), VEC_W'(0));
    capv = dut_out_data;
    for (int j = 1; j <= HOLD; j++) begin
      if (vary) dut_out_data = rand96();
      capv = dut_out_data;
      @(negedge clk);
      check("m_valid_in_hold", VEC_W'(bus.m_valid), VEC_W'(0));
      @(posedge clk);
      #1;
    end
    idx = 0;
    cyc = 0;
    stall = stall_first;
    while (idx < NW && cyc < 200) begin
      dut_out_data = rand96();
      if (stall > 0) begin
        bus.m_ready = 1'b0;
        stall--;
      end else begin
        bus.m_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      exp_w = capv[WORD_W*idx +: WORD_W];
      check("resp_valid", VEC_W'(bus.m_valid), VEC_W'(1));
      check("resp_data",  VEC_W'(bus.m_data),  VEC_W'(exp_w));
      check("resp_last",  VEC_W'(bus.m_last),  VEC_W'(idx == NW-1));
`ifdef FUZZ_VEC_DRV_PARITY_EN
      check("resp_parity", VEC_W'(bus.m_parity), VEC_W'(~^exp_w));
`endif
      if (bus.m_ready) idx++;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (idx < NW) check("resp_count", VEC_W'(idx), VEC_W'(NW));
    bus.m_ready = 1'b0;
    @(negedge clk);
    check("m_valid_after_resp", VEC_W'(bus.m_valid), VEC_W'(0));
    check("s_ready_after_resp", VEC_W'(bus.s_ready), VEC_W'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    bus.m_ready  = 1'b0;
    dut_out_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready",  VEC_W'(bus.s_ready), VEC_W'(0));
    check("rst_m_valid",  VEC_W'(bus.m_valid), VEC_W'(0));
    check("rst_m_data",   VEC_W'(bus.m_data),  VEC_W'(0));
    check("rst_m_last",   VEC_W'(bus.m_last),  VEC_W'(0));
    check("rst_clk_vec",  dut_clkin_data, '0);
    check("rst_dat_vec",  dut_in_data,    '0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_ready", VEC_W'(bus.s_ready), VEC_W'(1));
    @(posedge clk);
    #1;

    // Directed vector, fixed DUT result, 5-cycle initial back-pressure.
    words = '{32'h1, 32'h0, 32'h0, 32'h1, 32'h2, 32'h3};
    dut_out_data = 96'hAAAAAAAA_55555555_0000FFFF;
    run_txn(1'b0, 5);
    check("tp_clk_persist", dut_clkin_data, 96'h1);
    check("tp_dat_persist", dut_in_data, 96'h00000003_00000002_00000001);

    // Reset after four stimulus words discards the partial vector.
    for (int k = 0; k < 4; k++) send_word($urandom());
    rst = 1'b1;
    #2;
    check("midrst_clk_vec", dut_clkin_data, '0);
    check("midrst_dat_vec", dut_in_data,    '0);
    check("midrst_s_ready", VEC_W'(bus.s_ready), VEC_W'(0));
    check("midrst_m_valid", VEC_W'(bus.m_valid), VEC_W'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_clk = '0;
    exp_dat = '0;
    for (int k = 0; k < 2*NW; k++) words[k] = $urandom();
    run_txn(1'b1, 0);

    // Response words with known parity: 0x3 (even ones) and 0x1 (odd ones).
    for (int k = 0; k < 2*NW; k++) words[k] = $urandom();
    dut_out_data = 96'hDEADBEEF_00000001_00000003;
    run_txn(1'b0, 0);

    // Randomized transactions.
    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < 2*NW; k++) words[k] = $urandom();
      dut_out_data = rand96();
      run_txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
